// File: rtl/spm_drv_pkg.sv
// Shared types and sizing helpers for the spm_drv serial-parallel multiplier driver.
package spm_drv_pkg;

    localparam int DEF_SIZE  = 32;
    localparam int DEF_P_LAT = 1;
    localparam int PROD_W    = 2 * DEF_SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } spm_drv_state_t;

    // Ceiling log2, used to size the RUN counter (range 0 .. 2*SIZE+P_LAT-1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spm_drv.sv
// Operand/product streaming driver for one spm instance: CLR, bit-serial y, product shift-in.
// Build option: SPM_DRV_SIGNED_B_EN makes the multiplier b two's complement (sign-extended).
module spm_drv
    import spm_drv_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int P_LAT = DEF_P_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   in_a,
    input  logic [SIZE-1:0]   in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] out_prod,
    output logic              busy_o,
    output logic [SIZE-1:0]   spm_x_o,
    output logic              spm_y_o,
    input  logic              spm_p_i,
    output logic              spm_rst_o
);

    localparam int PW = 2 * SIZE;
    localparam int CW = clog2(PW + P_LAT);
    localparam logic [CW-1:0] CNT_LAST = CW'(PW + P_LAT - 1);
    localparam logic [CW-1:0] CNT_PLAT = CW'(P_LAT);

    spm_drv_state_t  state, state_nx;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] a_q;
    logic [PW-1:0]   bsh;
    logic [PW-1:0]   prod;
    logic [PW-1:0]   bext;

`ifdef SPM_DRV_SIGNED_B_EN
    assign bext = {{SIZE{in_b[SIZE-1]}}, in_b};
`else
    assign bext = {{SIZE{1'b0}}, in_b};
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_nx = CLR;
            CLR:     state_nx = RUN;
            RUN:     if (cnt == CNT_LAST) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Every output is a flop driven from the next state, so no input reaches an output combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_q       <= '0;
            bsh       <= '0;
            prod      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy_o    <= 1'b0;
            spm_x_o   <= '0;
            spm_y_o   <= 1'b0;
            spm_rst_o <= 1'b1;
        end else begin
            state     <= state_nx;
            in_ready  <= (state_nx == IDLE);
            out_valid <= (state_nx == DONE);
            busy_o    <= (state_nx != IDLE);
            spm_rst_o <= (state_nx == CLR);

            if (state_nx == IDLE)
                spm_x_o <= '0;
            else if (state == IDLE)
                spm_x_o <= in_a;
            else
                spm_x_o <= a_q;

            case (state)
                IDLE: begin
                    spm_y_o <= 1'b0;
                    cnt     <= '0;
                    if (state_nx == CLR) begin
                        a_q <= in_a;
                        bsh <= bext;
                    end
                end
                CLR: begin
                    // y bit 0 must be on the wire during the first RUN cycle.
                    cnt     <= '0;
                    spm_y_o <= bsh[0];
                    bsh     <= bsh >> 1;
                end
                RUN: begin
                    cnt     <= cnt + 1'b1;
                    spm_y_o <= bsh[0];
                    bsh     <= bsh >> 1;
                    // Product bit k appears P_LAT cycles after y bit k; shift in from the top, LSB lands at bit 0.
                    if (cnt >= CNT_PLAT)
                        prod <= {spm_p_i, prod[PW-1:1]};
                end
                default: ;
            endcase
        end
    end

    assign out_prod = prod;

endmodule

// File: doc/spm_drv.md
# spm_drv

Streaming front-end and back-end for the serial-parallel multiplier `spm`. It accepts a parallel operand pair over a valid/ready handshake and drives the multiplicand onto `spm.x`. It shifts the multiplier into `spm.y` LSB-first, then deserializes the `spm.p` bit stream into a 2·SIZE-bit product. It sits between a register-mapped or stream client and one `spm` instance, and owns that instance's per-operation clear.

## Interface
- `SIZE`, 32: operand width; must match the `spm` instance `size`, ≥ 2.
- `P_LAT`, 1: cycles from driving y bit k to product bit k being valid on `spm_p_i`.
- `clk` input 1: single clock; `spm` runs on the same clock.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: driver idle, can accept.
- `in_a` input SIZE: multiplicand, two's complement.
- `in_b` input SIZE: multiplier.
- `out_valid` output 1: product valid.
- `out_ready` input 1: consumer accepts product.
- `out_prod` output 2·SIZE: product.
- `busy_o` output 1: high in CLR/RUN/DONE.
- `spm_x_o` output SIZE: to `spm.x`.
- `spm_y_o` output 1: to `spm.y`.
- `spm_p_i` input 1: from `spm.p`.
- `spm_rst_o` output 1: registered clear, ORed with `rst` at `spm.rst` by the integrator.

## Operation
- FSM states: IDLE, CLR, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid`&`in_ready`, latch `a`/`b` and go to CLR.
- CLR: lasts one cycle. `spm_rst_o`=1, `spm_x_o`=a, `spm_y_o`=0, counter cnt cleared. Then go to RUN.
- Why CLR exists: the `spm` tail cell latches its sign-flag state and only a reset clears it. Every operation therefore starts with a clear.
- RUN: cnt runs 0 .. 2·SIZE+P_LAT−1.
  - `spm_y_o` = bext[cnt] for cnt < 2·SIZE, else 0.
  - bext is b extended to 2·SIZE bits (see Configuration).
  - For cnt ≥ P_LAT, capture `spm_p_i` into prod[cnt−P_LAT].
  - On the last cnt, go to DONE.
- DONE: `out_valid`=1, `out_prod` holds stable. On `out_ready`, go to IDLE.
- `spm_x_o` = a in CLR, RUN and DONE; 0 in IDLE.
- `in_a`/`in_b` are ignored outside IDLE. `out_ready` is ignored outside DONE.
- Arithmetic: `out_prod` = a × bext mod 2^(2·SIZE). a is always signed, because `spm` sign-handles x.
- Reset values: `in_ready`=0, `out_valid`=0, `out_prod`=0, `busy_o`=0, `spm_x_o`=0, `spm_y_o`=0, `spm_rst_o`=1; state is IDLE.
- First cycle after `rst` deasserts: `spm_rst_o` drops to 0 and `in_ready`=1.
- `rst` mid-operation: the operation is abandoned with no output, and reset values apply immediately (asynchronous).

## Timing
- Accept edge is E0. CLR occupies cycle 1. RUN occupies cycles 2 .. 2·SIZE+P_LAT+1.
- `out_valid` rises at cycle 2·SIZE+P_LAT+2; that is 67 for SIZE=32, P_LAT=1.
- Out handshake at edge Ek: `in_ready`=1 from cycle k+1.
- Max throughput: one product per 2·SIZE+P_LAT+3 cycles. No input/output overlap.
- All outputs are registered. No combinational path from `in_valid` or `out_ready` to any output.

## Configuration
- `SPM_DRV_SIGNED_B_EN` defined: b is two's complement. bext = sign-extend(b); the product is signed × signed.
- Not defined: bext = zero-extend(b); the product is signed a × unsigned b.

## Structure
- Package `spm_drv_pkg`:
  - state enum `spm_drv_state_t` (IDLE, CLR, RUN, DONE);
  - counter-width function clog2(2·SIZE+P_LAT);
  - localparam `PROD_W` = 2·SIZE.
- Single module, no sub-module. FSM, counter, b shift register and product shift-in register all live in `spm_drv`.

## Test plan
All cases use SIZE=32, P_LAT=1, driving a real `spm` instance.
- Basic: a=3, b=5 → `out_prod`=0x0000_0000_0000_000F; `out_valid` rises exactly at cycle 67 after accept.
- Signed, macro on: a=2, b=0xFFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE.
- Unsigned b, macro off: a=2, b=0xFFFF_FFFF → 0x0000_0001_FFFF_FFFE.
- Negative a: a=0x8000_0000, b=0x7FFF_FFFF → 0xC000_0000_8000_0000.
- Backpressure: `out_ready` held low 10 cycles after `out_valid` → `out_prod` stable, `in_ready`=0, `busy_o`=1 throughout.
- Reset mid-RUN: assert `rst` at RUN cycle 20.
  - `out_valid`=0 and `spm_rst_o`=1 at once.
  - A following a=7, b=6 yields 42, which also proves CLR isolates operations.
  - Then back-to-back ops with `out_ready` tied high, each correct, spaced 68 cycles.
